beverage_vend_ctrl_param: RTL

Parametrised vending-machine controller. Accepts half-dollar and one-dollar coin strobes, accumulates credit in half-dollar units, vends one of `NUM_PRODUCTS` products on selection, and returns change one unit per cycle. Optional auto-vend mode dispenses product 0 automatically as soon as credit reaches its price. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_credit_acc.sv | 49 ++++
 rtl/beverage_vend_ctrl_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared FSM state type, coin values and sizing helper for the
// beverage vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } vend_state_e;

   localparam int HALF_UNITS = 1;
   localparam int ONE_UNITS  = 2;

   // A single-product machine still carries a 1-bit product id.
   function automatic int id_width(input int num_products);
      return (num_products > 1) ? $clog2(num_products) : 1;
   endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: ceiling-checked add, subtract-price and decrement-by-one,
// with the can-accept flag computed on a one-bit-wider sum.
module vend_credit_acc #(
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CREDIT_W-1:0] add_val,
   input  logic                add_en,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] sub_val,
   input  logic                dec_en,
   output logic                can_accept,
   output logic [CREDIT_W-1:0] credit
);

   logic [CREDIT_W:0]   sum_s;
   logic [CREDIT_W-1:0] credit_r;
   logic [CREDIT_W-1:0] credit_nxt_s;

   assign sum_s      = {1'b0, credit_r} + {1'b0, add_val};
   assign can_accept = (sum_s <= (CREDIT_W+1)'(MAX_CREDIT));
   assign credit     = credit_r;

   // Next credit value; the controller never raises two controls at once.
   always_comb begin
      credit_nxt_s = credit_r;
      if (add_en && can_accept) begin
         credit_nxt_s = sum_s[CREDIT_W-1:0];
      end else if (sub_en) begin
         credit_nxt_s = (credit_r >= sub_val) ? (credit_r - sub_val) : {CREDIT_W{1'b0}};
      end else if (dec_en) begin
         credit_nxt_s = (credit_r != {CREDIT_W{1'b0}}) ? (credit_r - CREDIT_W'(1)) : {CREDIT_W{1'b0}};
      end else begin
         credit_nxt_s = credit_r;
      end
   end

   // Credit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_r <= {CREDIT_W{1'b0}};
      end else begin
         credit_r <= credit_nxt_s;
      end
   end

endmodule

// File: rtl/beverage_vend_ctrl_param.sv
// Parametrised vending controller: coin acceptance, product selection or
// auto-vend of product 0, dispense, and one-unit-per-cycle change return.
module beverage_vend_ctrl_param
   import vend_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int CREDIT_W     = 4,
   parameter int MAX_CREDIT   = 10,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {4'd5, 4'd4, 4'd2, 4'd3},
   parameter int AUTO_VEND    = 0,
   localparam int ID_W        = id_width(NUM_PRODUCTS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                half_dollar,
   input  logic                one_dollar,
   input  logic                sel_valid,
   input  logic [ID_W-1:0]     sel_id,
   input  logic                cancel,
   output logic                collect,
   output logic                coin_reject,
   output logic                dispense,
   output logic [ID_W-1:0]     dispense_id,
   output logic                change_out,
   output logic                sel_denied,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int PTBL = 1 << ID_W;

   vend_state_e         state_r;
   vend_state_e         next_state_s;
   logic [ID_W-1:0]     vend_id_r;
   logic [ID_W-1:0]     vend_id_nxt_s;

   logic [CREDIT_W-1:0] price_tbl_s [PTBL];
   logic [CREDIT_W-1:0] sel_price_s;
   logic [CREDIT_W-1:0] vend_price_s;
   logic                sel_in_range_s;

   logic [CREDIT_W-1:0] credit_s;
   logic [CREDIT_W-1:0] coin_val_s;
   logic [CREDIT_W-1:0] post_credit_s;
   logic                coin_present_s;
   logic                can_accept_s;
   logic                coin_ok_s;
   logic                add_en_s;
   logic                sub_en_s;
   logic                dec_en_s;

   logic                collect_s;
   logic                coin_reject_s;
   logic                dispense_s;
   logic [ID_W-1:0]     dispense_id_s;
   logic                change_s;
   logic                denied_s;
   logic                busy_s;

   logic                collect_r;
   logic                coin_reject_r;
   logic                dispense_r;
   logic [ID_W-1:0]     dispense_id_r;
   logic                change_r;
   logic                denied_r;
   logic                busy_r;

   // Unused table slots (non-power-of-two product counts) read as price 0.
   for (genvar i = 0; i < PTBL; i++) begin : g_price
      if (i < NUM_PRODUCTS) begin : g_used
         assign price_tbl_s[i] = PRICES[i*CREDIT_W +: CREDIT_W];
      end else begin : g_unused
         assign price_tbl_s[i] = {CREDIT_W{1'b0}};
      end
   end

   assign sel_in_range_s = (int'(sel_id) < NUM_PRODUCTS);
   assign sel_price_s    = price_tbl_s[sel_id];
   assign vend_price_s   = price_tbl_s[vend_id_r];

   // One dollar wins when both strobes coincide; the half is then refused.
   assign coin_present_s = one_dollar | half_dollar;
   assign coin_val_s     = one_dollar  ? CREDIT_W'(ONE_UNITS)  :
                           half_dollar ? CREDIT_W'(HALF_UNITS) : {CREDIT_W{1'b0}};

   vend_credit_acc #(
      .CREDIT_W   (CREDIT_W),
      .MAX_CREDIT (MAX_CREDIT)
   ) u_credit_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .add_val    (coin_val_s),
      .add_en     (add_en_s),
      .sub_en     (sub_en_s),
      .sub_val    (vend_price_s),
      .dec_en     (dec_en_s),
      .can_accept (can_accept_s),
      .credit     (credit_s)
   );

   // Next-state and pulse decode; priority in IDLE/CREDIT is cancel > selection > coin.
   always_comb begin
      next_state_s  = state_r;
      vend_id_nxt_s = vend_id_r;
      collect_s     = 1'b0;
      coin_reject_s = 1'b0;
      dispense_s    = 1'b0;
      dispense_id_s = {ID_W{1'b0}};
      change_s      = 1'b0;
      denied_s      = 1'b0;
      add_en_s      = 1'b0;
      sub_en_s      = 1'b0;
      dec_en_s      = 1'b0;
      coin_ok_s     = 1'b0;
      post_credit_s = credit_s;

      case (state_r)
         IDLE, CREDIT: begin
            if (cancel && (state_r == CREDIT)) begin
               next_state_s = CHANGE;
               coin_ok_s    = 1'b0;
            end else if ((AUTO_VEND == 0) && sel_valid) begin
               if (sel_in_range_s && (credit_s >= sel_price_s)) begin
                  next_state_s  = VEND;
                  vend_id_nxt_s = sel_id;
                  coin_ok_s     = 1'b0;
               end else begin
                  denied_s  = 1'b1;
                  coin_ok_s = 1'b1;
               end
            end else begin
               coin_ok_s = 1'b1;
            end

            if (coin_ok_s) begin
               add_en_s      = coin_present_s & can_accept_s;
               collect_s     = coin_present_s & can_accept_s;
               coin_reject_s = (coin_present_s & ~can_accept_s) | (one_dollar & half_dollar);
               post_credit_s = add_en_s ? (credit_s + coin_val_s) : credit_s;
               if ((AUTO_VEND != 0) && (post_credit_s >= price_tbl_s[0])) begin
                  next_state_s  = VEND;
                  vend_id_nxt_s = {ID_W{1'b0}};
               end else begin
                  next_state_s = (post_credit_s == {CREDIT_W{1'b0}}) ? IDLE : CREDIT;
               end
            end else begin
               coin_reject_s = coin_present_s;
            end
         end

         VEND: begin
            coin_reject_s = coin_present_s;
            dispense_s    = 1'b1;
            dispense_id_s = vend_id_r;
            sub_en_s      = 1'b1;
            next_state_s  = (credit_s > vend_price_s) ? CHANGE : IDLE;
         end

         CHANGE: begin
            coin_reject_s = coin_present_s;
            if (credit_s != {CREDIT_W{1'b0}}) begin
               change_s     = 1'b1;
               dec_en_s     = 1'b1;
               next_state_s = (credit_s == CREDIT_W'(1)) ? IDLE : CHANGE;
            end else begin
               next_state_s = IDLE;
            end
         end

         default: begin
            coin_reject_s = coin_present_s;
            next_state_s  = IDLE;
         end
      endcase

      busy_s = (next_state_s == VEND) || (next_state_s == CHANGE);
   end

   // State and latched product id.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         vend_id_r <= {ID_W{1'b0}};
      end else begin
         state_r   <= next_state_s;
         vend_id_r <= vend_id_nxt_s;
      end
   end

   // Registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collect_r     <= 1'b0;
         coin_reject_r <= 1'b0;
         dispense_r    <= 1'b0;
         dispense_id_r <= {ID_W{1'b0}};
         change_r      <= 1'b0;
         denied_r      <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         collect_r     <= collect_s;
         coin_reject_r <= coin_reject_s;
         dispense_r    <= dispense_s;
         dispense_id_r <= dispense_id_s;
         change_r      <= change_s;
         denied_r      <= denied_s;
         busy_r        <= busy_s;
      end
   end

   assign collect     = collect_r;
   assign coin_reject = coin_reject_r;
   assign dispense    = dispense_r;
   assign dispense_id = dispense_id_r;
   assign change_out  = change_r;
   assign sel_denied  = denied_r;
   assign credit      = credit_s;
   assign busy        = busy_r;

endmodule
